load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multicycle load/store engine between the processor datapath/control FSM and a word-organised 64-bit data memory. It takes one access request per instruction, with address, store data, size and sign mode. It performs lane alignment, byte-enable generation, misalignment checking and load sign/zero extension, and runs a req/ack handshake with memory. The control FSM stalls on busy and advances on done.

Parameters:
XLEN, 64, datapath and memory word width in bits (fixed at 64; 8 byte lanes)
ACK_TIMEOUT, 16, max cycles held in REQ without mem_ack before the access is aborted
TO_W, 5, width of the wait counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  access request pulse; sampled only in IDLE
is_store  in  1  1 = store, 0 = load
mem_size  in  2  00 byte, 01 half, 10 word, 11 double
is_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
addr  in  64  byte address from ALU result
wdata  in  64  store data (RD2), value in low bytes
busy  out  1  access in progress (ALIGN/REQ states)
done  out  1  one-cycle completion pulse
rdata  out  64  extended load result; registered, held until next load completes
misaligned  out  1  valid with done: access rejected, addr not size-aligned
fault  out  1  valid with done: ack timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable (qualified by mem_req)
mem_addr  out  64  {addr[63:3],3'b000}
mem_be  out  8  byte enables
mem_wdata  out  64  lane-shifted store data
mem_ack  in  1  memory accept/complete, single cycle
mem_rdata  in  64  load data, valid in the mem_ack cycle

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0, including rdata; wait counter 0. Reset during REQ drops mem_req immediately; the access is lost and no done is issued.
- States: IDLE, ALIGN, REQ, DONE.
- IDLE: on start=1, register is_store, mem_size, is_unsigned, addr and wdata, then go to ALIGN. No start means stay in IDLE.
- ALIGN: busy=1. Check alignment: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0.
  - Misaligned: go to DONE with misaligned flag set; no memory access.
  - Aligned: drive the memory outputs and go to REQ.
- REQ: mem_req=1, busy=1. mem_addr, mem_we, mem_be and mem_wdata are registered and must stay stable for the whole REQ.
  - mem_ack=1: for loads, capture extended data into rdata; go to DONE.
  - No ack: increment the counter. If counter==ACK_TIMEOUT-1, drop req and go to DONE with fault set.
- DONE: done=1 for exactly one cycle; misaligned and fault are valid this cycle only and are 0 otherwise; busy=0. Always return to IDLE.
- start is ignored outside IDLE; mem_ack is ignored outside REQ.
- Latency: start at cycle T, mem_req at T+2. An ack in cycle T+2+k gives done at T+3+k. A misaligned access gives done at T+2.
- mem_be: the size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0]. It is driven for loads too.
- mem_wdata: wdata << (8*addr[2:0]), truncated to 64 bits. mem_we = is_store during REQ.
- Load extraction: mem_rdata >> (8*addr[2:0]), then take the low 8/16/32/64 bits and extend by is_unsigned. Double ignores is_unsigned.
- Stores leave rdata unchanged. Faulted or misaligned loads leave rdata unchanged.

Decomposition:
- Package lsu_pkg:
  - mem_size_t enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - lsu_state_t enum
  - size_mask() function returning the 8-bit base mask
  - is_aligned() function
- Sub-module lsu_lane_align: purely combinational, containing the be/wdata shifter and the load extractor/extender. The FSM, registers and timeout counter stay in the top module.

Test Plan:
1. Byte store, addr=0x1003, wdata=0xAB, ack in first REQ cycle. Required: mem_addr=0x1000, mem_be=0x08, mem_wdata=0x00000000AB000000, mem_we=1; done 3 cycles after start.
2. Half load, addr=0x2006, mem_rdata=0x8001000000000000. Signed: rdata=0xFFFFFFFFFFFF8001. Unsigned: rdata=0x0000000000008001.
3. Word load at addr=0x1002. Required: mem_req never asserts; done=1 and misaligned=1 two cycles after start; rdata unchanged.
4. Double store at 0x3000, ack delayed 3 cycles. Required: mem_req high 4 cycles with mem_addr/mem_be=0xFF/mem_wdata stable; done the cycle after ack; start pulses during busy are ignored.
5. No ack, ACK_TIMEOUT=16. Required: mem_req high exactly 16 cycles, then done=1 with fault=1, misaligned=0.
6. Assert reset during REQ. Required: mem_req and busy fall without waiting for a clock edge; no done is issued; a following start completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM state
// encoding, byte-enable base masks and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ALIGN = 2'b01,
        ST_REQ   = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_t;

    // Byte-enable mask for an access of the given size sitting at lane 0.
    function automatic logic [7:0] size_mask(input mem_size_t size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // An access is aligned when its byte offset is a multiple of its size.
    function automatic logic is_aligned(input mem_size_t size, input logic [2:0] offset);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return (offset[0] == 1'b0);
            SZ_W:    return (offset[1:0] == 2'b00);
            default: return (offset == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-organised data-memory bus: a single-cycle req/ack handshake carrying
// a doubleword address, byte enables and lane-positioned data.
interface load_store_unit_if #(
    parameter int XLEN = 64
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   wdata;
    logic              ack;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and store-data shift toward the
// addressed lanes, and load-data extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  mem_size_t   size,
    input  logic [2:0]  offset,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] mem_rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata_lane,
    output logic [63:0] load_data
);
    logic [63:0] rdata_shifted;

    assign be         = size_mask(size) << offset;
    assign wdata_lane = wdata << {offset, 3'b000};

    // Bring the addressed bytes down to lane 0, then extend to full width.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        rdata_shifted = mem_rdata >> {offset, 3'b000};
        load_data     = rdata_shifted;
        case (size)
            SZ_B: load_data = is_unsigned ? {56'b0, rdata_shifted[7:0]}
                                          : {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {48'b0, rdata_shifted[15:0]}
                                          : {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            SZ_W: load_data = is_unsigned ? {32'b0, rdata_shifted[31:0]}
                                          : {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: load_data = rdata_shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store engine: captures one request, checks alignment,
// runs the memory req/ack handshake with an ack timeout, and reports the
// result with a one-cycle done pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_store,
    input  logic [1:0]       mem_size,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  rdata,
    output logic             misaligned,
    output logic             fault,
    load_store_unit_if.master mem
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ALIGN = ST_ALIGN;
    localparam logic [1:0] S_REQ   = ST_REQ;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]      state;
    logic            store_q;
    mem_size_t       size_q;
    logic            unsigned_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [TO_W-1:0] wait_cnt;
    logic            misal_q;
    logic            fault_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [7:0]      mem_be_q;
    logic [XLEN-1:0] mem_wdata_q;

    logic [7:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_load;

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .offset      (addr_q[2:0]),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .mem_rdata   (mem.rdata),
        .be          (lane_be),
        .wdata_lane  (lane_wdata),
        .load_data   (lane_load)
    );

    // Control FSM with request capture, memory-output registers and ack timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            store_q     <= 1'b0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            misal_q     <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        store_q    <= is_store;
                        size_q     <= mem_size_t'(mem_size);
                        unsigned_q <= is_unsigned;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        state      <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (!is_aligned(size_q, addr_q[2:0])) begin
                        misal_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        mem_addr_q  <= {addr_q[XLEN-1:3], 3'b000};
                        mem_be_q    <= lane_be;
                        mem_wdata_q <= lane_wdata;
                        wait_cnt    <= '0;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.ack) begin
                        if (!store_q) begin
                            rdata_q <= lane_load;
                        end
                        state <= S_DONE;
                    end else if (wait_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        fault_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: begin
                    misal_q <= 1'b0;
                    fault_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == S_ALIGN) || (state == S_REQ);
    assign done       = (state == S_DONE);
    assign misaligned = done && misal_q;
    assign fault      = done && fault_q;
    assign rdata      = rdata_q;

    assign mem.req    = (state == S_REQ);
    assign mem.we     = (state == S_REQ) && store_q;
    assign mem.addr   = mem_addr_q;
    assign mem.be     = mem_be_q;
    assign mem.wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: alignment, lane steering, load
// extension, ack delay, timeout and asynchronous reset.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  mem_size;
    logic        is_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic [63:0] rdata;
    logic        misaligned;
    logic        fault;

    int checks = 0;
    int errors = 0;

    load_store_unit_if #(.XLEN(64)) mem_bus ();

    load_store_unit #(.XLEN(64), .ACK_TIMEOUT(16), .TO_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_store    (is_store),
        .mem_size    (mem_size),
        .is_unsigned (is_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .misaligned  (misaligned),
        .fault       (fault),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns #1 after the edge that enters ALIGN.
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] wd);
        is_store    = st;
        mem_size    = sz;
        is_unsigned = uns;
        addr        = a;
        wdata       = wd;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({busy, done, misaligned, fault, mem_bus.req, mem_bus.we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 000000", {busy, done, misaligned, fault, mem_bus.req, mem_bus.we});
        end
        checks++;
        if (rdata !== 64'h0 || mem_bus.addr !== 64'h0 || mem_bus.be !== 8'h0 || mem_bus.wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h be %h wdata %h exp all zero", rdata, mem_bus.addr, mem_bus.be, mem_bus.wdata);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_byte_store();
        issue(1'b1, 2'b00, 1'b0, 64'h1003, 64'hAB);
        tick();
        checks++;
        if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_req: req %b we %b busy %b exp 1 1 1", mem_bus.req, mem_bus.we, busy);
        end
        checks++;
        if (mem_bus.addr !== 64'h1000 || mem_bus.be !== 8'h08) begin
            errors++;
            $display("FAIL t1_addr_be: addr %h be %h exp 1000 08", mem_bus.addr, mem_bus.be);
        end
        checks++;
        if (mem_bus.wdata !== 64'h00000000AB000000) begin
            errors++;
            $display("FAIL t1_wdata: got %h exp 00000000ab000000", mem_bus.wdata);
        end
        mem_bus.ack = 1'b1;
        tick();
        mem_bus.ack = 1'b0;
        checks++;
        if ({done, misaligned, fault, busy, mem_bus.req} !== 5'b10000) begin
            errors++;
            $display("FAIL t1_done: done/mis/fault/busy/req %b exp 10000", {done, misaligned, fault, busy, mem_bus.req});
        end
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL t1_rdata_kept: got %h exp 0", rdata);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_pulse: got %b exp 0", done);
        end
    endtask

    task automatic half_load(input logic uns, input logic [63:0] exp, input string tag);
        issue(1'b0, 2'b01, uns, 64'h2006, 64'h0);
        tick();
        checks++;
        if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b0 || mem_bus.be !== 8'hC0 || mem_bus.addr !== 64'h2000) begin
            errors++;
            $display("FAIL %s_req: req %b we %b be %h addr %h exp 1 0 c0 2000", tag, mem_bus.req, mem_bus.we, mem_bus.be, mem_bus.addr);
        end
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 64'h8001000000000000;
        tick();
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 64'h0;
        checks++;
        if (done !== 1'b1 || rdata !== exp) begin
            errors++;
            $display("FAIL %s_rdata: done %b rdata %h exp 1 %h", tag, done, rdata, exp);
        end
        tick();
    endtask

    task automatic test_half_load();
        half_load(1'b0, 64'hFFFFFFFFFFFF8001, "t2_signed");
        half_load(1'b1, 64'h0000000000008001, "t2_unsigned");
    endtask

    task automatic test_misaligned();
        issue(1'b0, 2'b10, 1'b0, 64'h1002, 64'h0);
        checks++;
        if (mem_bus.req !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL t3_align: req %b busy %b done %b exp 0 1 0", mem_bus.req, busy, done);
        end
        tick();
        checks++;
        if ({done, misaligned, fault, mem_bus.req} !== 4'b1100) begin
            errors++;
            $display("FAIL t3_done: done/mis/fault/req %b exp 1100", {done, misaligned, fault, mem_bus.req});
        end
        checks++;
        if (rdata !== 64'h0000000000008001) begin
            errors++;
            $display("FAIL t3_rdata_kept: got %h exp 8001", rdata);
        end
        tick();
        checks++;
        if (misaligned !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t3_flag_clear: mis %b done %b exp 0 0", misaligned, done);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b11, 1'b0, 64'h3000, 64'h0123456789ABCDEF);
        // Stray start pulses with a different request while busy.
        start    = 1'b1;
        is_store = 1'b0;
        addr     = 64'h5001;
        mem_size = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1 || mem_bus.addr !== 64'h3000 ||
                mem_bus.be !== 8'hFF || mem_bus.wdata !== 64'h0123456789ABCDEF) begin
                errors++;
                $display("FAIL t4_stable%0d: req %b we %b addr %h be %h wdata %h", i, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.be, mem_bus.wdata);
            end
            if (i == 3) mem_bus.ack = 1'b1;
        end
        tick();
        mem_bus.ack = 1'b0;
        start       = 1'b0;
        checks++;
        if ({done, fault, misaligned, mem_bus.req} !== 4'b1000) begin
            errors++;
            $display("FAIL t4_done: done/fault/mis/req %b exp 1000", {done, fault, misaligned, mem_bus.req});
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t4_no_extra: busy %b done %b exp 0 0", busy, done);
        end
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        bit  seen_done  = 0;
        issue(1'b0, 2'b11, 1'b0, 64'h4000, 64'h0);
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            if (mem_bus.req === 1'b1) req_cycles++;
            if (done === 1'b1) begin
                seen_done = 1;
                checks++;
                if (fault !== 1'b1 || misaligned !== 1'b0) begin
                    errors++;
                    $display("FAIL t5_flags: fault %b mis %b exp 1 0", fault, misaligned);
                end
            end
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL t5_no_done: done not seen within 40 cycles");
        end
        checks++;
        if (req_cycles != 16) begin
            errors++;
            $display("FAIL t5_req_cycles: got %0d exp 16", req_cycles);
        end
        checks++;
        if (rdata !== 64'h0000000000008001) begin
            errors++;
            $display("FAIL t5_rdata_kept: got %h exp 8001", rdata);
        end
        tick();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL t5_fault_clear: got %b exp 0", fault);
        end
    endtask

    task automatic test_reset_in_req();
        bit spurious = 0;
        issue(1'b1, 2'b00, 1'b0, 64'h10, 64'h55);
        tick();
        checks++;
        if (mem_bus.req !== 1'b1) begin
            errors++;
            $display("FAIL t6_in_req: req %b exp 1", mem_bus.req);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_bus.req !== 1'b0 || busy !== 1'b0 || rdata !== 64'h0) begin
            errors++;
            $display("FAIL t6_async: req %b busy %b rdata %h exp 0 0 0", mem_bus.req, busy, rdata);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL t6_no_done: done pulsed after reset");
        end
        issue(1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
        tick();
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 64'hFFFFFFFFFFFFFF7F;
        tick();
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 64'h0;
        checks++;
        if (done !== 1'b1 || rdata !== 64'h000000000000007F) begin
            errors++;
            $display("FAIL t6_after: done %b rdata %h exp 1 7f", done, rdata);
        end
        tick();
    endtask

    initial begin
        start         = 1'b0;
        is_store      = 1'b0;
        mem_size      = 2'b00;
        is_unsigned   = 1'b0;
        addr          = 64'h0;
        wdata         = 64'h0;
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 64'h0;
        test_reset();
        test_byte_store();
        test_half_load();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
